i2c_temp_reader: RTL and testbench
==================================

Name: i2c_temp_reader

Overview:
- Sequences a fixed two-byte I2C read from the on-board temperature sensor (device address DEV_ADDR).
- Runs entirely on clk_100MHz with an internal quarter-bit tick enable, so no derived clock net is used.
- Delivers the 16-bit raw temperature word to the alarm/display logic with a one-cycle valid strobe.
- The bus is driven open-drain: both lines are released or pulled low, never driven high.

Parameters:
- DEV_ADDR, 7'h4B, 7-bit I2C slave address sent in the address byte.
- TICK_DIV, 250, clk_100MHz cycles per quarter-bit tick. Gives a 400 kHz tick and a 100 kHz SCL.

Ports:
- clk_100MHz  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a read transaction.
- sda_in  in  1  sampled SDA line level (synchronised externally).
- scl_drive_low  out  1  1 = pull SCL low, 0 = release.
- sda_drive_low  out  1  1 = pull SDA low, 0 = release.
- busy  out  1  high while a transaction is in progress.
- temp_data  out  16  last successfully read word, {MSB byte, LSB byte}.
- data_valid  out  1  one-cycle pulse when temp_data updates.
- ack_error  out  1  sticky flag: slave NACKed the address byte. Cleared on the next accepted start.

Behaviour:
- Reset values:
  - scl_drive_low=0, sda_drive_low=0 (bus released).
  - busy=0, temp_data=16'h0000, data_valid=0, ack_error=0.
  - State=IDLE; tick counter=0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 only while not IDLE.
  - A tick is asserted on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
  - Counter is held at 0 in IDLE.
- Bit timing, 4 ticks per bit (q0..q3):
  - q0: SCL low; SDA updated.
  - q1: SCL low.
  - q2: SCL released; SDA sampled on the q2 tick.
  - q3: SCL released.
- States and transitions; each advance happens on a tick:
  - IDLE:
    - Accept start when busy=0. On acceptance, busy=1 and ack_error=0 on the next cycle.
    - start while busy=1 is ignored.
  - START, 4 ticks: SCL released, SDA released for q0-q1, SDA low for q2-q3. The START edge is SDA falling while SCL is high.
  - ADDR, 32 ticks: sends {DEV_ADDR, 1'b1} MSB first. A 1 bit means release SDA; a 0 bit means drive SDA low.
  - ADDR_ACK, 4 ticks: SDA released; sda_in sampled at q2.
    - Sampled 1: set ack_error and go to STOP.
    - Sampled 0: go to RD_MSB.
  - RD_MSB, 32 ticks: SDA released; bits shifted in MSB first at each q2.
  - M_ACK, 4 ticks: SDA driven low.
  - RD_LSB, 32 ticks: as RD_MSB.
  - M_NACK, 4 ticks: SDA released.
  - STOP, 4 ticks: SCL low with SDA low at q0-q1; SCL released at q2; SDA released at q3. The STOP edge is SDA rising while SCL is high.
  - DONE, 1 cycle, not tick-gated:
    - If there was no ack error, load temp_data and pulse data_valid.
    - busy=0 in the same cycle; return to IDLE.
- Transaction length:
  - Successful read: 116 ticks = 29000 cycles from the start-accept cycle to the DONE cycle, ±1 cycle.
  - NACK path: START + ADDR + ADDR_ACK + STOP = 44 ticks. No data_valid; temp_data is retained.
- Bit counter: 3 bits, wraps 7→0 at the end of each byte and triggers the state change. Shift register is 8 bits per byte.
- Clock stretching is not supported; SCL line state is not read back.
- Reset mid-transaction:
  - All outputs return to their reset values on the next cycle.
  - The bus is released immediately. No STOP is generated.
  - temp_data is cleared.
- start and reset asserted together: reset wins.
- A start in the same cycle as DONE is ignored. It is accepted from the following cycle.

Test Plan:
- Reset: hold reset for 5 cycles → all outputs 0, both drive_low outputs 0, no SCL activity for 1000 cycles.
- Normal read: slave model ACKs 0x97 (DEV_ADDR=0x4B, R) and returns 0x0C, 0x80 → SCL period 1000 cycles.
  - Exactly one START and one STOP.
  - Master ACK after byte 1, NACK after byte 2.
  - temp_data=16'h0C80 with a one-cycle data_valid about 29000 cycles after start; busy falls in the same cycle.
- Address NACK: slave leaves SDA high at ADDR_ACK → ack_error=1, STOP issued, no data_valid, temp_data keeps its prior value.
  - A following start with an ACKing slave clears ack_error.
- Start while busy: pulse start at 5000 and 15000 cycles into a transaction → single transaction, result unchanged.
- Reset mid-read: assert reset during RD_LSB → both drive_low outputs 0 and busy=0 next cycle, temp_data=0.
  - A new start then completes normally, returning 16'h1234.
- Back-to-back: start one cycle after DONE → second transaction begins, and both return correct values (0x0C80 then 0x0D00).

Source files
------------

// File: rtl/i2c_temp_reader.sv
// Fixed two-byte I2C read from the on-board temperature sensor, open-drain bus,
// timed by a quarter-bit tick enable derived from the 100 MHz system clock.
module i2c_temp_reader #(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter int         TICK_DIV = 250
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        start,
  input  logic        sda_in,
  output logic        scl_drive_low,
  output logic        sda_drive_low,
  output logic        busy,
  output logic [15:0] temp_data,
  output logic        data_valid,
  output logic        ack_error
);

  localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]        ADDR_BYTE = {DEV_ADDR, 1'b1};

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_RD_MSB   = 4'd4;
  localparam logic [3:0] S_M_ACK    = 4'd5;
  localparam logic [3:0] S_RD_LSB   = 4'd6;
  localparam logic [3:0] S_M_NACK   = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       msb_q, msb_d;
  logic [15:0]      temp_q, temp_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;

  logic tick, last_qtr, byte_end, sample;

  assign tick     = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
  assign last_qtr = (qtr_q == 2'd3);
  assign byte_end = last_qtr && (bit_q == 3'd7);
  assign sample   = tick && (qtr_q == 2'd2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    msb_d   = msb_q;
    temp_d  = temp_q;
    busy_d  = busy_q;
    err_d   = err_q;
    valid_d = 1'b0;

    if (state_q == S_IDLE || state_q == S_DONE || tick) cnt_d = '0;
    if (state_q == S_IDLE || state_q == S_DONE) qtr_d = 2'd0;
    else if (tick) qtr_d = qtr_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          state_d = S_START;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_START:  if (tick && last_qtr) state_d = S_ADDR;
      S_ADDR: begin
        if (tick && last_qtr) bit_d = bit_q + 3'd1;
        if (tick && byte_end) state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        if (sample && sda_in) err_d = 1'b1;
        if (tick && last_qtr) state_d = err_q ? S_STOP : S_RD_MSB;
      end
      S_RD_MSB: begin
        if (sample) shift_d = {shift_q[6:0], sda_in};
        if (tick && last_qtr) bit_d = bit_q + 3'd1;
        if (tick && byte_end) begin
          msb_d   = shift_q;
          state_d = S_M_ACK;
        end
      end
      S_M_ACK:  if (tick && last_qtr) state_d = S_RD_LSB;
      S_RD_LSB: begin
        if (sample) shift_d = {shift_q[6:0], sda_in};
        if (tick && last_qtr) bit_d = bit_q + 3'd1;
        if (tick && byte_end) state_d = S_M_NACK;
      end
      S_M_NACK: if (tick && last_qtr) state_d = S_STOP;
      S_STOP:   if (tick && last_qtr) state_d = S_DONE;
      S_DONE: begin
        if (!err_q) begin
          temp_d  = {msb_q, shift_q};
          valid_d = 1'b1;
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line levels decoded from the current quarter; registered so the pins never glitch.
  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_q)
      S_START:  sda_d = qtr_q[1];
      S_ADDR: begin
        scl_d = ~qtr_q[1];
        sda_d = ~ADDR_BYTE[3'd7 - bit_q];
      end
      S_ADDR_ACK, S_RD_MSB, S_RD_LSB, S_M_NACK: scl_d = ~qtr_q[1];
      S_M_ACK: begin
        scl_d = ~qtr_q[1];
        sda_d = 1'b1;
      end
      S_STOP: begin
        scl_d = ~qtr_q[1];
        sda_d = (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      temp_q  <= 16'h0000;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      temp_q  <= temp_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    shift_q <= shift_d;
    msb_q   <= msb_d;
  end

  assign scl_drive_low = scl_q;
  assign sda_drive_low = sda_q;
  assign busy          = busy_q;
  assign temp_data     = temp_q;
  assign data_valid    = valid_q;
  assign ack_error     = err_q;

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Bench for i2c_temp_reader: behavioural I2C slave on the open-drain bus and a
// queue of expected words matched against each data_valid pulse.
module tb_i2c_temp_reader;

  localparam int TDIV   = 25;
  localparam int TXN_T  = 116;
  localparam int NACK_T = 44;

  typedef struct {
    logic        ack;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        exp_valid;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sda_in;
  logic        scl_drive_low, sda_drive_low, busy, data_valid, ack_error;
  logic [15:0] temp_data;

  logic slave_pull = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = ~scl_drive_low;
  assign sda_line = ~(sda_drive_low | slave_pull);
  assign sda_in   = sda_line;

  always #5 clk = ~clk;

  i2c_temp_reader #(.DEV_ADDR(7'h4B), .TICK_DIV(TDIV)) dut (
    .clk_100MHz    (clk),
    .reset         (reset),
    .start         (start),
    .sda_in        (sda_in),
    .scl_drive_low (scl_drive_low),
    .sda_drive_low (sda_drive_low),
    .busy          (busy),
    .temp_data     (temp_data),
    .data_valid    (data_valid),
    .ack_error     (ack_error)
  );

  // Slave model: watches the lines, records every bit on SCL rise, drives on SCL fall.
  logic       cfg_ack = 1'b1;
  logic [7:0] cfg_b0 = 8'h00;
  logic [7:0] cfg_b1 = 8'h00;
  int   nbit = 0, start_cnt = 0, stop_cnt = 0, rise_n = 0;
  int   gcyc = 0, t_rise = 0, scl_period = 0;
  logic bits [0:31];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  function automatic logic pull_for(int n);
    if (!cfg_ack) return 1'b0;
    if (n == 8) return 1'b1;
    if (n >= 9 && n <= 16) return ~cfg_b0[3'(16 - n)];
    if (n >= 18 && n <= 25) return ~cfg_b1[3'(25 - n)];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    gcyc <= gcyc + 1;
    if (reset) begin
      slave_pull <= 1'b0;
      nbit       <= 0;
    end else if (prev_scl && scl_line && prev_sda && !sda_line) begin
      start_cnt  <= start_cnt + 1;
      nbit       <= 0;
      rise_n     <= 0;
      slave_pull <= 1'b0;
    end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
      stop_cnt   <= stop_cnt + 1;
      slave_pull <= 1'b0;
    end else if (!prev_scl && scl_line) begin
      if (nbit < 32) bits[nbit] <= sda_line;
      if (rise_n == 0) t_rise <= gcyc;
      else if (rise_n == 1) scl_period <= gcyc - t_rise;
      rise_n <= rise_n + 1;
      nbit   <= nbit + 1;
    end else if (prev_scl && !scl_line) begin
      slave_pull <= pull_for(nbit);
    end
    prev_scl <= scl_line;
    prev_sda <= sda_line;
  end

  int          n_tests = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (data_valid) begin
      valid_cnt++;
      check("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("temp_data_sb", {16'h0, temp_data}, {16'h0, exp_q.pop_front()});
      check("busy_on_valid", 32'(busy), 0);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit pokes, input bit b2b);
    int n, s0, p0, v0, ticks, lo, hi;
    logic [7:0] addr;
    ticks   = v.ack ? TXN_T : NACK_T;
    cfg_ack = v.ack;
    cfg_b0  = v.b0;
    cfg_b1  = v.b1;
    s0 = start_cnt;
    p0 = stop_cnt;
    v0 = valid_cnt;
    if (v.exp_valid) exp_q.push_back(v.exp_data);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check("busy_set", 32'(busy), 1);
    check("err_cleared", 32'(ack_error), 0);
    while (busy && n < 200 * TDIV) begin
      start = pokes && (n == 20 * TDIV || n == 60 * TDIV);
      step();
      n++;
    end
    start = 1'b0;
    check("txn_done", 32'(busy), 0);
    lo = ticks * TDIV + 1;
    hi = ticks * TDIV + 3;
    n_tests++;
    if (n < lo || n > hi) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, expected %0d..%0d", n, lo, hi);
    end
    check("valid_count", 32'(valid_cnt - v0), 32'(v.exp_valid));
    check("ack_error", 32'(ack_error), 32'(v.exp_err));
    check("temp_data", {16'h0, temp_data}, {16'h0, v.exp_data});
    check("start_count", 32'(start_cnt - s0), 1);
    check("stop_count", 32'(stop_cnt - p0), 1);
    addr = 8'h00;
    for (int i = 0; i < 8; i++) addr = {addr[6:0], bits[i]};
    check("addr_byte", 32'(addr), 32'h97);
    check("scl_period", 32'(scl_period), 32'(4 * TDIV));
    if (v.ack) begin
      check("master_ack", 32'(bits[17]), 0);
      check("master_nack", 32'(bits[26]), 1);
    end
    if (!b2b) begin
      step();
      check("valid_pulse", 32'(data_valid), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    vec_t v;
    int   act;
    tbl[0] = '{1'b1, 8'h0C, 8'h80, 1'b1, 1'b0, 16'h0C80};
    tbl[1] = '{1'b0, 8'h55, 8'h66, 1'b0, 1'b1, 16'h0C80};
    tbl[2] = '{1'b1, 8'h0D, 8'h00, 1'b1, 1'b0, 16'h0D00};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 16'hFF01};
    tbl[4] = '{1'b1, 8'h00, 8'hFE, 1'b1, 1'b0, 16'h00FE};

    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rst_scl", 32'(scl_drive_low), 0);
    check("rst_sda", 32'(sda_drive_low), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_temp", {16'h0, temp_data}, 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_err", 32'(ack_error), 0);

    start = 1'b1;
    step();
    check("reset_beats_start", 32'(busy), 0);
    reset = 1'b0;
    start = 1'b0;
    act = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (scl_drive_low || sda_drive_low || busy) act++;
    end
    check("idle_bus_quiet", 32'(act), 0);

    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i], 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) step();
    end

    v = '{1'b1, 8'h5A, 8'hA5, 1'b1, 1'b0, 16'h5AA5};
    run_txn(v, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step();

    cfg_ack = 1'b1;
    cfg_b0  = 8'h12;
    cfg_b1  = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 90 * TDIV; i++) step();
    check("midread_busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    check("midrst_scl", 32'(scl_drive_low), 0);
    check("midrst_sda", 32'(sda_drive_low), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_temp", {16'h0, temp_data}, 0);
    check("midrst_err", 32'(ack_error), 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step();
    v = '{1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 16'h1234};
    run_txn(v, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step();

    run_txn(tbl[0], 1'b0, 1'b1);
    run_txn(tbl[2], 1'b0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
